seg_scan_decoder: RTL and testbench

Reverse path of the board's hex-to-seven-segment encoders. A time-multiplexed scanner selects one display digit at a time, samples its active-low 7-segment pattern, and decodes the pattern back to a hex nibble. The decoded nibbles are assembled into one result word, with per-digit error and blank flags. It sits beside the ALU/accumulator display path and lets the self-test logic read back what the HEX displays are showing.

---
 rtl/seg_scan_decoder.sv | 112 +++++++++++
 tb/tb_seg_scan_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Scans a multiplexed seven-segment display one digit at a time and decodes
// each active-low pattern back to a hex nibble, with per-digit error and blank flags.
module seg_scan_decoder #(
    parameter int NUM_DIGITS = 6,
    parameter int SETTLE     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [6:0]              seg_in,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic [NUM_DIGITS-1:0]   blank_mask
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       dec;

    // Returns {blank, err, nibble}; blank and unknown patterns both decode to nibble 0.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        logic [5:0] r;
        case (seg)
            7'h40:   r = 6'h00;
            7'h79:   r = 6'h01;
            7'h24:   r = 6'h02;
            7'h30:   r = 6'h03;
            7'h19:   r = 6'h04;
            7'h12:   r = 6'h05;
            7'h02:   r = 6'h06;
            7'h78:   r = 6'h07;
            7'h00:   r = 6'h08;
            7'h10:   r = 6'h09;
            7'h08:   r = 6'h0A;
            7'h03:   r = 6'h0B;
            7'h46:   r = 6'h0C;
            7'h21:   r = 6'h0D;
            7'h06:   r = 6'h0E;
            7'h0E:   r = 6'h0F;
            7'h7F:   r = 6'b10_0000;
            default: r = 6'b01_0000;
        endcase
        return r;
    endfunction

    assign dec = decode_seg(seg_in);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            digit_sel  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            value      <= '0;
            err_mask   <= '0;
            blank_mask <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= SCAN;
                        idx        <= '0;
                        cnt        <= '0;
                        digit_sel  <= NUM_DIGITS'(1);
                        busy       <= 1'b1;
                        value      <= '0;
                        err_mask   <= '0;
                        blank_mask <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (cnt == LAST_CNT) begin
                        // Only the last cycle of each selection window is sampled.
                        cnt                      <= '0;
                        value[4*int'(idx) +: 4]  <= dec[3:0];
                        err_mask[idx]            <= dec[4];
                        blank_mask[idx]          <= dec[5];
                        if (idx == LAST_IDX) begin
                            state     <= DONE;
                            digit_sel <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx       <= idx + 1'b1;
                            digit_sel <= digit_sel << 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a display model drives seg_in from digit_sel, and a
// font-table reference model predicts the decoded word for two parameter sets.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [6:0]  seg0, seg1;
    logic [5:0]  sel0, err0, blank0, prev_sel0;
    logic        busy0, done0, busy1, done1;
    logic [23:0] val0;
    logic [3:0]  sel1, err1, blank1;
    logic [15:0] val1;

    logic [6:0]  disp0 [6];
    logic [6:0]  disp1 [4];
    logic [6:0]  font  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [23:0] ev0;
    logic [5:0]  ee0, eb0;
    logic [15:0] ev1;
    logic [3:0]  ee1, eb1;
    int          tests = 0;
    int          fails = 0;

    seg_scan_decoder #(.NUM_DIGITS(6), .SETTLE(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .seg_in(seg0),
        .digit_sel(sel0), .busy(busy0), .done(done0), .value(val0),
        .err_mask(err0), .blank_mask(blank0)
    );

    seg_scan_decoder #(.NUM_DIGITS(4), .SETTLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .seg_in(seg1),
        .digit_sel(sel1), .busy(busy1), .done(done1), .value(val1),
        .err_mask(err1), .blank_mask(blank1)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) prev_sel0 <= sel0;

    // Display with a junk pattern in the first cycle of each 2-cycle window.
    always_comb begin
        seg0 = 7'h7F;
        for (int i = 0; i < 6; i++)
            if (sel0[i]) seg0 = (sel0 != prev_sel0) ? 7'h5A : disp0[i];
    end

    always_comb begin
        seg1 = 7'h7F;
        for (int i = 0; i < 4; i++)
            if (sel1[i]) seg1 = disp1[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {blank, err, nibble} by searching the font table.
    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        if (p == 7'h7F) return 6'b10_0000;
        for (int n = 0; n < 16; n++)
            if (font[n] == p) return {2'b00, 4'(n)};
        return 6'b01_0000;
    endfunction

    task automatic model0();
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r = ref_decode(disp0[i]);
            ev0[4*i +: 4] = r[3:0];
            ee0[i] = r[4];
            eb0[i] = r[5];
        end
    endtask

    task automatic model1();
        logic [5:0] r;
        for (int i = 0; i < 4; i++) begin
            r = ref_decode(disp1[i]);
            ev1[4*i +: 4] = r[3:0];
            ee1[i] = r[4];
            eb1[i] = r[5];
        end
    endtask

    function automatic logic [6:0] rand_pat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return font[$urandom_range(0, 15)];
        if (r < 8) return 7'h7F;
        return 7'($urandom);
    endfunction

    // Cycle k counts from 1 = first cycle after the accepting edge.
    task automatic check_cycle0(input int k);
        logic [5:0] es;
        es = (k <= 12) ? 6'(1 << ((k - 1) / 2)) : 6'd0;
        chk($sformatf("sel0 k%0d", k), 32'(sel0), 32'(es));
        chk($sformatf("busy0 k%0d", k), 32'(busy0), 32'(k <= 12));
        chk($sformatf("done0 k%0d", k), 32'(done0), 32'(k == 13));
        if (k == 1) begin
            chk("val0 cleared", 32'(val0), 32'd0);
            chk("err0 cleared", 32'(err0), 32'd0);
            chk("blank0 cleared", 32'(blank0), 32'd0);
        end
        if (k == 13) begin
            chk("val0", 32'(val0), 32'(ev0));
            chk("err0", 32'(err0), 32'(ee0));
            chk("blank0", 32'(blank0), 32'(eb0));
        end
    endtask

    task automatic check_cycle1(input int k);
        logic [3:0] es;
        es = (k <= 4) ? 4'(1 << (k - 1)) : 4'd0;
        chk($sformatf("sel1 k%0d", k), 32'(sel1), 32'(es));
        chk($sformatf("busy1 k%0d", k), 32'(busy1), 32'(k <= 4));
        chk($sformatf("done1 k%0d", k), 32'(done1), 32'(k == 5));
        if (k == 5) begin
            chk("val1", 32'(val1), 32'(ev1));
            chk("err1", 32'(err1), 32'(ee1));
            chk("blank1", 32'(blank1), 32'(eb1));
        end
    endtask

    task automatic scan0(input bit pulse_mid, input bit hold);
        model0();
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start0 = hold || (pulse_mid && (k == 3 || k == 10));
            check_cycle0(k);
        end
        if (hold) begin
            for (int k = 1; k <= 13; k++) begin
                @(negedge clk);
                start0 = 1'b0;
                check_cycle0(k);
            end
        end
        start0 = 1'b0;
    endtask

    task automatic scan1();
        model1();
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            check_cycle1(k);
        end
    endtask

    task automatic check_idle0(input string tag);
        chk({tag, " sel0"}, 32'(sel0), 32'd0);
        chk({tag, " busy0"}, 32'(busy0), 32'd0);
        chk({tag, " done0"}, 32'(done0), 32'd0);
        chk({tag, " val0"}, 32'(val0), 32'd0);
        chk({tag, " err0"}, 32'(err0), 32'd0);
        chk({tag, " blank0"}, 32'(blank0), 32'd0);
    endtask

    task automatic set_word0(input logic [23:0] w);
        for (int i = 0; i < 6; i++) disp0[i] = font[w[4*i +: 4]];
    endtask

    initial begin
        set_word0(24'h000000);
        for (int i = 0; i < 4; i++) disp1[i] = 7'h7F;

        repeat (2) @(negedge clk);
        check_idle0("reset");
        chk("reset sel1", 32'(sel1), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset done1", 32'(done1), 32'd0);
        chk("reset val1", 32'(val1), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle0("idle");

        // Normal "1234Ab"
        set_word0(24'h1234AB);
        scan0(1'b0, 1'b0);
        chk("normal value", 32'(val0), 32'h1234AB);
        chk("normal err", 32'(err0), 32'd0);

        // Invalid and blank digits
        set_word0(24'h333333);
        disp0[2] = 7'h7E;
        disp0[4] = 7'h7F;
        disp0[5] = 7'h7F;
        scan0(1'b0, 1'b0);
        chk("inval err", 32'(err0), 32'b000100);
        chk("inval blank", 32'(blank0), 32'b110000);
        repeat (3) @(negedge clk);
        chk("result held", 32'(val0), 32'(ev0));

        // Start pulses during the scan are ignored
        set_word0(24'h1234AB);
        scan0(1'b1, 1'b0);
        @(negedge clk);
        chk("no extra done", 32'(done0), 32'd0);
        chk("no requeue", 32'(busy0), 32'd0);

        // Start held through done restarts immediately
        set_word0(24'h9C5E07);
        scan0(1'b0, 1'b1);

        // Reset mid-scan discards the partial result
        set_word0(24'hFEDCBA);
        model0();
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            check_cycle0(k);
        end
        reset_n = 1'b0;
        for (int k = 8; k <= 16; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            check_idle0($sformatf("midreset k%0d", k));
        end
        scan0(1'b0, 1'b0);
        chk("after reset value", 32'(val0), 32'hFEDCBA);

        // Four digits, one-cycle settle, "F0E1"
        disp1[3] = font[15];
        disp1[2] = font[0];
        disp1[1] = font[14];
        disp1[0] = font[1];
        scan1();
        chk("f0e1 value", 32'(val1), 32'hF0E1);

        repeat (6) begin
            for (int i = 0; i < 6; i++) disp0[i] = rand_pat();
            scan0(1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (4) begin
            for (int i = 0; i < 4; i++) disp1[i] = rand_pat();
            scan1();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
